// File: rtl/rpct_update_gen.sv
// Return-address prediction table training stream: buffers resolved call/ret
// events, drains one per cycle as update pulses, and audits rets against a shadow stack.
module rpct_update_gen #(
  parameter int FIFO_DEPTH  = 4,
  parameter int STACK_DEPTH = 8,
  parameter int CNT_BITS    = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_call,
  input  logic                in_is_ret,
  input  logic [31:0]         in_pc,
  input  logic [31:0]         in_target,
  input  logic                flush,
  output logic                is_call,
  output logic                is_ret,
  output logic [31:0]         call_pc,
  output logic [31:0]         ret_pc,
  output logic [31:0]         jrra_pc,
  output logic [CNT_BITS-1:0] ret_mismatch_cnt,
  output logic [CNT_BITS-1:0] ret_underflow_cnt
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int SAW = $clog2(STACK_DEPTH);

  // Event buffer: storage needs no reset, only the pointers and occupancy do
  logic              fifo_call [FIFO_DEPTH];
  logic [31:0]       fifo_pc   [FIFO_DEPTH];
  logic [31:0]       fifo_tgt  [FIFO_DEPTH];
  logic [FAW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [FAW:0]      count_reg;
  logic              ready_en_reg;

  logic [31:0]       stack_reg [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] valid_reg;
  logic [SAW-1:0]    sp_reg;

  logic              is_call_reg, is_ret_reg;
  logic [31:0]       call_pc_reg, ret_pc_reg, jrra_pc_reg;
  logic [CNT_BITS-1:0] mismatch_reg, underflow_reg;

  logic              full, push, pop, pop_call, pop_ret;
  logic              head_call;
  logic [31:0]       head_pc, head_tgt, ret_addr, top_addr;
  logic [SAW-1:0]    sp_dec;
  logic              top_valid;

  assign full      = (count_reg == (FAW+1)'(FIFO_DEPTH));
  assign in_ready  = ready_en_reg & ~full;
  assign push      = in_valid & in_ready & (in_is_call | in_is_ret);
  assign pop       = (count_reg != '0) & ~flush;

  assign head_call = fifo_call[rd_ptr_reg];
  assign head_pc   = fifo_pc[rd_ptr_reg];
  assign head_tgt  = fifo_tgt[rd_ptr_reg];
  assign pop_call  = pop & head_call;
  assign pop_ret   = pop & ~head_call;
  assign ret_addr  = head_pc + 32'd8;

  assign sp_dec    = sp_reg - SAW'(1);
  assign top_valid = valid_reg[sp_dec];
  assign top_addr  = stack_reg[sp_dec];

  // A call takes priority when both event flags are set
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_call[wr_ptr_reg] <= in_is_call;
      fifo_pc[wr_ptr_reg]   <= in_pc;
      fifo_tgt[wr_ptr_reg]  <= in_target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + FAW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + FAW'(1);
        count_reg <= count_reg + (FAW+1)'(push) - (FAW+1)'(pop);
      end
    end
  end

  // Overflow silently overwrites the oldest entry since the pointer just wraps
  always_ff @(posedge clk) begin
    if (pop_call) stack_reg[sp_reg] <= ret_addr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_reg     <= '0;
      sp_reg        <= '0;
      mismatch_reg  <= '0;
      underflow_reg <= '0;
    end else if (pop_call) begin
      valid_reg[sp_reg] <= 1'b1;
      sp_reg            <= sp_reg + SAW'(1);
    end else if (pop_ret) begin
      if (top_valid) begin
        valid_reg[sp_dec] <= 1'b0;
        sp_reg            <= sp_dec;
        if (top_addr != head_tgt && mismatch_reg != '1)
          mismatch_reg <= mismatch_reg + CNT_BITS'(1);
      end else if (underflow_reg != '1) begin
        underflow_reg <= underflow_reg + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_call_reg <= 1'b0;
      is_ret_reg  <= 1'b0;
      call_pc_reg <= '0;
      ret_pc_reg  <= '0;
      jrra_pc_reg <= '0;
    end else begin
      is_call_reg <= pop_call;
      is_ret_reg  <= pop_ret;
      if (pop_call) begin
        call_pc_reg <= head_pc;
        ret_pc_reg  <= ret_addr;
        jrra_pc_reg <= '0;
      end else if (pop_ret) begin
        call_pc_reg <= '0;
        ret_pc_reg  <= head_tgt;
        jrra_pc_reg <= head_pc;
      end
    end
  end

  assign is_call           = is_call_reg;
  assign is_ret            = is_ret_reg;
  assign call_pc           = call_pc_reg;
  assign ret_pc            = ret_pc_reg;
  assign jrra_pc           = jrra_pc_reg;
  assign ret_mismatch_cnt  = mismatch_reg;
  assign ret_underflow_cnt = underflow_reg;

endmodule

// File: tb/tb_rpct_update_gen.sv
// Directed and random checks of rpct_update_gen against a queue-based model of
// the event buffer and a bounded list model of the return-address stack.
module tb_rpct_update_gen;
  localparam int CNT = 4;
  localparam int SAT = (1 << CNT) - 1;

  logic clk = 1'b0, resetn = 1'b0;
  logic in_valid = 1'b0, in_is_call = 1'b0, in_is_ret = 1'b0, flush = 1'b0;
  logic [31:0] in_pc = '0, in_target = '0;
  logic in_ready, is_call, is_ret;
  logic [31:0] call_pc, ret_pc, jrra_pc;
  logic [CNT-1:0] ret_mismatch_cnt, ret_underflow_cnt;

  rpct_update_gen #(.FIFO_DEPTH(4), .STACK_DEPTH(8), .CNT_BITS(CNT)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_call(in_is_call), .in_is_ret(in_is_ret), .in_pc(in_pc),
    .in_target(in_target), .flush(flush), .is_call(is_call), .is_ret(is_ret),
    .call_pc(call_pc), .ret_pc(ret_pc), .jrra_pc(jrra_pc),
    .ret_mismatch_cnt(ret_mismatch_cnt), .ret_underflow_cnt(ret_underflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          call;
    logic [31:0] pc;
    logic [31:0] tgt;
  } ev_t;

  int vectors = 0, miscompares = 0;
  ev_t q[$];
  logic [31:0] stk[$];
  logic [31:0] e_is_call, e_is_ret, e_call_pc, e_ret_pc, e_jrra_pc;
  int e_mis, e_und;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("t=%0t %s observed %h expected %h", $time, tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    stk.delete();
    e_is_call = 0; e_is_ret = 0; e_call_pc = 0; e_ret_pc = 0; e_jrra_pc = 0;
    e_mis = 0; e_und = 0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_is_call"}, 32'(is_call), e_is_call);
    chk({pfx, "_is_ret"},  32'(is_ret),  e_is_ret);
    chk({pfx, "_call_pc"}, call_pc, e_call_pc);
    chk({pfx, "_ret_pc"},  ret_pc,  e_ret_pc);
    chk({pfx, "_jrra_pc"}, jrra_pc, e_jrra_pc);
    chk({pfx, "_mis_cnt"}, 32'(ret_mismatch_cnt),  e_mis);
    chk({pfx, "_und_cnt"}, 32'(ret_underflow_cnt), e_und);
  endtask

  // One clock cycle: drive inputs, predict the edge, then check after it
  task automatic step(input bit v, input bit c, input bit r,
                      input logic [31:0] pc, input logic [31:0] tgt, input bit fl);
    ev_t ev;
    bit  rdy;
    logic [31:0] top;
    in_valid = v; in_is_call = c; in_is_ret = r;
    in_pc = pc; in_target = tgt; flush = fl;
    #1;
    rdy = (q.size() < 4);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    e_is_call = 0; e_is_ret = 0;
    if (q.size() > 0 && !fl) begin
      ev = q.pop_front();
      if (ev.call) begin
        e_is_call = 1;
        e_call_pc = ev.pc; e_ret_pc = ev.pc + 32'd8; e_jrra_pc = 0;
        stk.push_back(ev.pc + 32'd8);
        if (stk.size() > 8) void'(stk.pop_front());
      end else begin
        e_is_ret = 1;
        e_call_pc = 0; e_ret_pc = ev.tgt; e_jrra_pc = ev.pc;
        if (stk.size() == 0) begin
          if (e_und < SAT) e_und++;
        end else begin
          top = stk.pop_back();
          if (top != ev.tgt && e_mis < SAT) e_mis++;
        end
      end
    end
    if (fl) q.delete();
    else if (v && rdy && (c || r)) q.push_back('{call: c, pc: pc, tgt: tgt});
    @(posedge clk); #1;
    check_outputs("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    int mis0, und0;
    logic [31:0] pc, tgt;
    bit c, r, fl;
    model_reset();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    check_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Ret with nothing on the stack underflows
    step(1, 0, 1, 32'h0000_2000, 32'h0000_1234, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_ret_pc", ret_pc, 32'h0000_1234);
    chk("t3_und", 32'(ret_underflow_cnt), 32'h1);

    // Single call, pulse two edges after it is presented
    step(1, 1, 0, 32'hBFC0_0100, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_is_call", 32'(is_call), 32'h1);
    chk("t1_call_pc", call_pc, 32'hBFC0_0100);
    chk("t1_ret_pc",  ret_pc,  32'hBFC0_0108);
    idle(1);

    // Matching call/ret pair back to back
    step(1, 1, 0, 32'h8000_0010, 32'h0, 0);
    step(1, 0, 1, 32'h8000_0400, 32'h8000_0018, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_jrra", jrra_pc, 32'h8000_0400);
    idle(2);

    // Back-to-back burst with a both-flags event and a neither-flag event
    step(1, 1, 0, 32'h0000_0A00, 32'h0, 0);
    step(1, 1, 1, 32'h0000_0B00, 32'h0000_0C00, 0);
    step(1, 0, 0, 32'h0000_0D00, 32'h0, 0);
    step(1, 0, 1, 32'h0000_0E00, 32'h0000_0B08, 0);
    step(1, 1, 0, 32'hFFFF_FFFC, 32'h0, 0);
    idle(3);

    // Nine calls overflow the eight-entry stack; ninth ret underflows
    mis0 = e_mis; und0 = e_und;
    for (int k = 1; k <= 9; k++) step(1, 1, 0, 32'(k * 32'h100), 32'h0, 0);
    for (int k = 9; k >= 1; k--) step(1, 0, 1, 32'h4000_0000, 32'(k * 32'h100 + 8), 0);
    idle(2);
    chk("t5_mis_delta", 32'(int'(ret_mismatch_cnt) - mis0), 32'h0);
    chk("t5_und_delta", 32'(int'(ret_underflow_cnt) - und0), 32'h1);

    // Flush discards buffered events
    step(1, 1, 0, 32'h0000_5000, 32'h0, 0);
    step(1, 1, 0, 32'h0000_5100, 32'h0, 0);
    step(1, 0, 1, 32'h0000_5200, 32'h0, 1);
    idle(3);

    // Reset while pulses are in flight
    step(1, 1, 0, 32'h0000_6000, 32'h0, 0);
    step(1, 0, 1, 32'h0000_6100, 32'h1, 0);
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("amid_in_ready", 32'(in_ready), 32'h0);
    check_outputs("amid");
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Random traffic, with occasional matching targets, flushes and pc wrap
    for (int i = 0; i < 300; i++) begin
      c  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 1) == 0);
      fl = ($urandom_range(0, 15) == 0);
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom;
      tgt = (stk.size() > 0 && $urandom_range(0, 1) == 0) ? stk[$] : $urandom;
      step($urandom_range(0, 3) != 0, c, r, pc, tgt, fl);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
